// File: rtl/alu_pkg.sv
// ----------------------------------------------------------------------------
// alu_pkg
// Definitions shared by the ID/EX pipeline slice and its decode helper.
//   - WIDTH_DEFAULT       : default operand datapath width.
//   - alu_op_e            : main-control ALU class codes.
//   - FUNCT_*             : R-type function field codes that are supported.
//   - slice_sig_e         : select code for the ALU bit-slices.
//   - decode_t / make_decode : bundled decode result and a constructor.
// ----------------------------------------------------------------------------
package alu_pkg;

    localparam int WIDTH_DEFAULT = 32;

    typedef enum logic [1:0] {
        ALU_OP_ADD   = 2'b00,
        ALU_OP_SUB   = 2'b01,
        ALU_OP_RTYPE = 2'b10,
        ALU_OP_BAD   = 2'b11
    } alu_op_e;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    typedef enum logic [1:0] {
        SIG_AND  = 2'b00,
        SIG_OR   = 2'b01,
        SIG_ADD  = 2'b10,
        SIG_LESS = 2'b11
    } slice_sig_e;

    typedef struct packed {
        slice_sig_e signal;
        logic       invert_b;
        logic       cin;
        logic       illegal;
    } decode_t;

    function automatic decode_t make_decode(slice_sig_e signal, logic invert_b,
                                            logic cin, logic illegal);
        decode_t d;
        d.signal   = signal;
        d.invert_b = invert_b;
        d.cin      = cin;
        d.illegal  = illegal;
        return d;
    endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// ----------------------------------------------------------------------------
// id_ex_stage_if
// Bundles the decode-side handshake, the forwarding buses and the ALU-side
// handshake of the ID/EX stage.
//   master : the environment (decode stage, later stages, ALU stage).
//   slave  : the id_ex_stage itself.
// ----------------------------------------------------------------------------
interface id_ex_stage_if #(
    parameter int WIDTH = alu_pkg::WIDTH_DEFAULT
);

    // Decode-stage side
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_rs_data;
    logic [WIDTH-1:0] in_rt_data;
    logic [4:0]       in_rs_addr;
    logic [4:0]       in_rt_addr;
    logic [4:0]       in_rd_addr;
    logic [1:0]       in_alu_op;
    logic [5:0]       in_funct;
    logic             flush;

    // Forwarding buses from EX/MEM and MEM/WB
    logic             fwd_exmem_we;
    logic [4:0]       fwd_exmem_addr;
    logic [WIDTH-1:0] fwd_exmem_data;
    logic             fwd_memwb_we;
    logic [4:0]       fwd_memwb_addr;
    logic [WIDTH-1:0] fwd_memwb_data;

    // ALU-stage side
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_a;
    logic [WIDTH-1:0] out_b;
    logic [1:0]       out_signal;
    logic             out_invert_b;
    logic             out_cin;
    logic [4:0]       out_rd_addr;
    logic             out_illegal;

    modport master (
        output in_valid, in_rs_data, in_rt_data, in_rs_addr, in_rt_addr,
               in_rd_addr, in_alu_op, in_funct, flush,
               fwd_exmem_we, fwd_exmem_addr, fwd_exmem_data,
               fwd_memwb_we, fwd_memwb_addr, fwd_memwb_data, out_ready,
        input  in_ready, out_valid, out_a, out_b, out_signal, out_invert_b,
               out_cin, out_rd_addr, out_illegal
    );

    modport slave (
        input  in_valid, in_rs_data, in_rt_data, in_rs_addr, in_rt_addr,
               in_rd_addr, in_alu_op, in_funct, flush,
               fwd_exmem_we, fwd_exmem_addr, fwd_exmem_data,
               fwd_memwb_we, fwd_memwb_addr, fwd_memwb_data, out_ready,
        output in_ready, out_valid, out_a, out_b, out_signal, out_invert_b,
               out_cin, out_rd_addr, out_illegal
    );

endinterface

// File: rtl/id_ex_stage_alu_decode.sv
// ----------------------------------------------------------------------------
// alu_decode
// Combinational translation of main-control ALU class and R-type funct into
// the bit-slice controls.
//   alu_op   in  2  ALU class from main control
//   funct    in  6  R-type function field
//   signal   out 2  slice select (AND/OR/ADD/LESS)
//   invert_b out 1  invert the B operand
//   cin      out 1  carry into bit 0
//   illegal  out 1  combination is not supported
// ----------------------------------------------------------------------------
module alu_decode
    import alu_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    output logic [1:0] signal,
    output logic       invert_b,
    output logic       cin,
    output logic       illegal
);

    decode_t dec;

    // Unsupported encodings fall back to a plain ADD with the illegal flag
    // raised, so the datapath still sees a well-defined operation.
    always_comb begin
        dec = make_decode(SIG_ADD, 1'b0, 1'b0, 1'b1);
        case (alu_op_e'(alu_op))
            ALU_OP_ADD: dec = make_decode(SIG_ADD, 1'b0, 1'b0, 1'b0);
            ALU_OP_SUB: dec = make_decode(SIG_ADD, 1'b1, 1'b1, 1'b0);
            ALU_OP_RTYPE: begin
                case (funct)
                    FUNCT_ADD: dec = make_decode(SIG_ADD,  1'b0, 1'b0, 1'b0);
                    FUNCT_SUB: dec = make_decode(SIG_ADD,  1'b1, 1'b1, 1'b0);
                    FUNCT_AND: dec = make_decode(SIG_AND,  1'b0, 1'b0, 1'b0);
                    FUNCT_OR:  dec = make_decode(SIG_OR,   1'b0, 1'b0, 1'b0);
                    FUNCT_SLT: dec = make_decode(SIG_LESS, 1'b1, 1'b1, 1'b0);
                    default:   dec = make_decode(SIG_ADD,  1'b0, 1'b0, 1'b1);
                endcase
            end
            default: dec = make_decode(SIG_ADD, 1'b0, 1'b0, 1'b1);
        endcase
    end

    assign signal   = dec.signal;
    assign invert_b = dec.invert_b;
    assign cin      = dec.cin;
    assign illegal  = dec.illegal;

endmodule

// File: rtl/id_ex_stage.sv
// ----------------------------------------------------------------------------
// id_ex_stage
// ID/EX pipeline register with ALU control decode and operand forwarding.
//   clk  in  1  clock, rising edge
//   rst  in  1  synchronous active-high reset
//   bus  slave modport of id_ex_stage_if:
//        in_valid/in_ready handshake plus operands and register numbers,
//        flush, EX/MEM and MEM/WB forwarding buses,
//        out_valid/out_ready handshake plus registered ALU controls.
// While an instruction is held waiting for the ALU stage, its operands keep
// tracking the forwarding buses so a late writeback is not missed.
// ----------------------------------------------------------------------------
module id_ex_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
)(
    input logic         clk,
    input logic         rst,
    id_ex_stage_if.slave bus
);

    logic [1:0] dec_signal;
    logic       dec_invert_b;
    logic       dec_cin;
    logic       dec_illegal;

    logic [4:0] rs_addr_q;
    logic [4:0] rt_addr_q;

    logic capture;
    logic hold;

    logic [WIDTH-1:0] cap_a;
    logic [WIDTH-1:0] cap_b;
    logic [WIDTH-1:0] hold_a;
    logic [WIDTH-1:0] hold_b;

    alu_decode u_decode (
        .alu_op   (bus.in_alu_op),
        .funct    (bus.in_funct),
        .signal   (dec_signal),
        .invert_b (dec_invert_b),
        .cin      (dec_cin),
        .illegal  (dec_illegal)
    );

    // EX/MEM has the newer result so it wins; register 0 is hard-wired zero
    // and must never pick up a forwarded value.
    function automatic logic [WIDTH-1:0] forward(
        input logic [4:0]       src,
        input logic [WIDTH-1:0] fallback,
        input logic             exmem_we,
        input logic [4:0]       exmem_addr,
        input logic [WIDTH-1:0] exmem_data,
        input logic             memwb_we,
        input logic [4:0]       memwb_addr,
        input logic [WIDTH-1:0] memwb_data
    );
        if (src != 5'd0 && exmem_we && exmem_addr == src) begin
            return exmem_data;
        end else if (src != 5'd0 && memwb_we && memwb_addr == src) begin
            return memwb_data;
        end
        return fallback;
    endfunction

    assign bus.in_ready = !bus.out_valid || bus.out_ready;
    assign capture      = bus.in_valid && bus.in_ready && !bus.flush;
    assign hold         = bus.out_valid && !bus.out_ready;

    assign cap_a = forward(bus.in_rs_addr, bus.in_rs_data,
                           bus.fwd_exmem_we, bus.fwd_exmem_addr, bus.fwd_exmem_data,
                           bus.fwd_memwb_we, bus.fwd_memwb_addr, bus.fwd_memwb_data);
    assign cap_b = forward(bus.in_rt_addr, bus.in_rt_data,
                           bus.fwd_exmem_we, bus.fwd_exmem_addr, bus.fwd_exmem_data,
                           bus.fwd_memwb_we, bus.fwd_memwb_addr, bus.fwd_memwb_data);

    // Held operands fall back to their own current value when nothing matches.
    assign hold_a = forward(rs_addr_q, bus.out_a,
                            bus.fwd_exmem_we, bus.fwd_exmem_addr, bus.fwd_exmem_data,
                            bus.fwd_memwb_we, bus.fwd_memwb_addr, bus.fwd_memwb_data);
    assign hold_b = forward(rt_addr_q, bus.out_b,
                            bus.fwd_exmem_we, bus.fwd_exmem_addr, bus.fwd_exmem_data,
                            bus.fwd_memwb_we, bus.fwd_memwb_addr, bus.fwd_memwb_data);

    // Priority: reset, then flush, then capture, then hold. When nothing
    // happens only the valid bit drops; data outputs keep their last value.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_valid    <= 1'b0;
            bus.out_a        <= '0;
            bus.out_b        <= '0;
            bus.out_signal   <= 2'b00;
            bus.out_invert_b <= 1'b0;
            bus.out_cin      <= 1'b0;
            bus.out_rd_addr  <= 5'd0;
            bus.out_illegal  <= 1'b0;
            rs_addr_q        <= 5'd0;
            rt_addr_q        <= 5'd0;
        end else if (bus.flush) begin
            bus.out_valid    <= 1'b0;
        end else if (capture) begin
            bus.out_valid    <= 1'b1;
            bus.out_a        <= cap_a;
            bus.out_b        <= cap_b;
            bus.out_signal   <= dec_signal;
            bus.out_invert_b <= dec_invert_b;
            bus.out_cin      <= dec_cin;
            bus.out_rd_addr  <= bus.in_rd_addr;
            bus.out_illegal  <= dec_illegal;
            rs_addr_q        <= bus.in_rs_addr;
            rt_addr_q        <= bus.in_rt_addr;
        end else if (hold) begin
            bus.out_a        <= hold_a;
            bus.out_b        <= hold_b;
        end else begin
            bus.out_valid    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// ----------------------------------------------------------------------------
// tb_id_ex_stage
// Self-checking bench for id_ex_stage: directed scenarios followed by random
// traffic, all compared against a behavioural model of the stage.
// ----------------------------------------------------------------------------
module tb_id_ex_stage;

    localparam int W = 32;

    logic clk;
    logic rst;

    id_ex_stage_if #(.WIDTH(W)) bus ();

    id_ex_stage #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model state: what the ALU stage should currently see.
    logic         m_valid;
    logic [W-1:0] m_a, m_b;
    logic [1:0]   m_sig;
    logic         m_inv, m_cin, m_ill;
    logic [4:0]   m_rd, m_rs, m_rt;

    task automatic checkOutput(input string tag, input logic [63:0] got,
                               input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Controls {signal, invert_b, cin, illegal} straight from the opcode table.
    function automatic logic [4:0] decodeModel(input logic [1:0] op, input logic [5:0] fn);
        if (op == 2'd0) return {2'b10, 1'b0, 1'b0, 1'b0};
        if (op == 2'd1) return {2'b10, 1'b1, 1'b1, 1'b0};
        if (op == 2'd2) begin
            if (fn == 6'd32) return {2'b10, 1'b0, 1'b0, 1'b0};
            if (fn == 6'd34) return {2'b10, 1'b1, 1'b1, 1'b0};
            if (fn == 6'd36) return {2'b00, 1'b0, 1'b0, 1'b0};
            if (fn == 6'd37) return {2'b01, 1'b0, 1'b0, 1'b0};
            if (fn == 6'd42) return {2'b11, 1'b1, 1'b1, 1'b0};
        end
        return {2'b10, 1'b0, 1'b0, 1'b1};
    endfunction

    function automatic logic [W-1:0] fwdModel(input logic [4:0] src, input logic [W-1:0] dflt);
        if (src == 5'd0) return dflt;
        if (bus.fwd_exmem_we && bus.fwd_exmem_addr == src) return bus.fwd_exmem_data;
        if (bus.fwd_memwb_we && bus.fwd_memwb_addr == src) return bus.fwd_memwb_data;
        return dflt;
    endfunction

    // Advance one clock with the inputs currently driven, updating the model
    // and comparing every observable output.
    task automatic applyStimulus();
        logic         accept, waiting;
        logic [4:0]   d;
        logic         n_valid;
        logic [W-1:0] n_a, n_b;
        logic [1:0]   n_sig;
        logic         n_inv, n_cin, n_ill;
        logic [4:0]   n_rd, n_rs, n_rt;

        @(negedge clk);
        checkOutput("in_ready", {63'd0, bus.in_ready}, {63'd0, (!m_valid || bus.out_ready)});

        accept  = bus.in_valid && (!m_valid || bus.out_ready);
        waiting = m_valid && !bus.out_ready;
        d = decodeModel(bus.in_alu_op, bus.in_funct);
        n_valid = m_valid; n_a = m_a; n_b = m_b; n_sig = m_sig; n_inv = m_inv;
        n_cin = m_cin; n_ill = m_ill; n_rd = m_rd; n_rs = m_rs; n_rt = m_rt;

        if (rst) begin
            n_valid = 0; n_a = 0; n_b = 0; n_sig = 0; n_inv = 0; n_cin = 0;
            n_ill = 0; n_rd = 0; n_rs = 0; n_rt = 0;
        end else if (bus.flush) begin
            n_valid = 0;
        end else if (accept) begin
            n_valid = 1;
            n_a = fwdModel(bus.in_rs_addr, bus.in_rs_data);
            n_b = fwdModel(bus.in_rt_addr, bus.in_rt_data);
            {n_sig, n_inv, n_cin, n_ill} = d;
            n_rd = bus.in_rd_addr; n_rs = bus.in_rs_addr; n_rt = bus.in_rt_addr;
        end else if (waiting) begin
            n_a = fwdModel(m_rs, m_a);
            n_b = fwdModel(m_rt, m_b);
        end else begin
            n_valid = 0;
        end

        @(posedge clk);
        #1;
        m_valid = n_valid; m_a = n_a; m_b = n_b; m_sig = n_sig; m_inv = n_inv;
        m_cin = n_cin; m_ill = n_ill; m_rd = n_rd; m_rs = n_rs; m_rt = n_rt;

        checkOutput("out_valid",    {63'd0, bus.out_valid},    {63'd0, m_valid});
        checkOutput("out_a",        {32'd0, bus.out_a},        {32'd0, m_a});
        checkOutput("out_b",        {32'd0, bus.out_b},        {32'd0, m_b});
        checkOutput("out_signal",   {62'd0, bus.out_signal},   {62'd0, m_sig});
        checkOutput("out_invert_b", {63'd0, bus.out_invert_b}, {63'd0, m_inv});
        checkOutput("out_cin",      {63'd0, bus.out_cin},      {63'd0, m_cin});
        checkOutput("out_rd_addr",  {59'd0, bus.out_rd_addr},  {59'd0, m_rd});
        checkOutput("out_illegal",  {63'd0, bus.out_illegal},  {63'd0, m_ill});
    endtask

    task automatic setInstr(input logic [1:0] op, input logic [5:0] fn,
                            input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                            input logic [W-1:0] rsd, input logic [W-1:0] rtd);
        bus.in_valid = 1; bus.in_alu_op = op; bus.in_funct = fn;
        bus.in_rs_addr = rs; bus.in_rt_addr = rt; bus.in_rd_addr = rd;
        bus.in_rs_data = rsd; bus.in_rt_data = rtd;
    endtask

    task automatic clearFwd();
        bus.fwd_exmem_we = 0; bus.fwd_exmem_addr = 0; bus.fwd_exmem_data = 0;
        bus.fwd_memwb_we = 0; bus.fwd_memwb_addr = 0; bus.fwd_memwb_data = 0;
    endtask

    initial begin
        logic [5:0] functs [6];
        functs[0] = 6'd32; functs[1] = 6'd34; functs[2] = 6'd36;
        functs[3] = 6'd37; functs[4] = 6'd42; functs[5] = 6'd0;

        rst = 1; bus.flush = 0; bus.out_ready = 0;
        setInstr(0, 0, 0, 0, 0, 0, 0);
        bus.in_valid = 0;
        clearFwd();

        // Bring registers to a known value before the model starts tracking.
        @(posedge clk); #1;
        m_valid = 0; m_a = 0; m_b = 0; m_sig = 0; m_inv = 0; m_cin = 0;
        m_ill = 0; m_rd = 0; m_rs = 0; m_rt = 0;
        applyStimulus();
        checkOutput("reset_in_ready", {63'd0, bus.in_ready}, 64'd1);
        rst = 0;

        // SLT with plain register operands.
        bus.out_ready = 1;
        setInstr(2'b10, 6'b101010, 5, 9, 1, 32'd5, 32'd9);
        applyStimulus();
        checkOutput("slt_valid",  {63'd0, bus.out_valid}, 64'd1);
        checkOutput("slt_signal", {62'd0, bus.out_signal}, 64'd3);
        checkOutput("slt_inv",    {63'd0, bus.out_invert_b}, 64'd1);
        checkOutput("slt_cin",    {63'd0, bus.out_cin}, 64'd1);
        checkOutput("slt_a",      {32'd0, bus.out_a}, 64'd5);
        checkOutput("slt_b",      {32'd0, bus.out_b}, 64'd9);

        // EX/MEM beats MEM/WB; register 0 is never forwarded.
        setInstr(2'b00, 0, 3, 4, 2, 32'h99, 32'h98);
        bus.fwd_exmem_we = 1; bus.fwd_exmem_addr = 3; bus.fwd_exmem_data = 32'h11;
        bus.fwd_memwb_we = 1; bus.fwd_memwb_addr = 3; bus.fwd_memwb_data = 32'h22;
        applyStimulus();
        checkOutput("fwd_prio_a", {32'd0, bus.out_a}, 64'h11);
        setInstr(2'b00, 0, 0, 4, 2, 32'h99, 32'h98);
        bus.fwd_exmem_addr = 0; bus.fwd_memwb_addr = 0;
        applyStimulus();
        checkOutput("fwd_r0_a", {32'd0, bus.out_a}, 64'h99);
        clearFwd();

        // Hold for three cycles with a late MEM/WB write to rt.
        setInstr(2'b10, 6'b100000, 6, 7, 3, 32'h60, 32'h70);
        applyStimulus();
        bus.in_valid = 0; bus.out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) begin
                bus.fwd_memwb_we = 1; bus.fwd_memwb_addr = 7; bus.fwd_memwb_data = 32'h44;
            end else begin
                clearFwd();
            end
            applyStimulus();
            checkOutput("hold_in_ready", {63'd0, bus.in_ready}, 64'd0);
            checkOutput("hold_rd",       {59'd0, bus.out_rd_addr}, 64'd3);
        end
        checkOutput("hold_b", {32'd0, bus.out_b}, 64'h44);
        checkOutput("hold_a", {32'd0, bus.out_a}, 64'h60);

        // Flush alongside a new instruction while one is still valid.
        setInstr(2'b00, 0, 1, 2, 9, 32'h1, 32'h2);
        bus.flush = 1;
        applyStimulus();
        checkOutput("flush_valid", {63'd0, bus.out_valid}, 64'd0);
        bus.flush = 0; bus.in_valid = 0; bus.out_ready = 1;
        applyStimulus();
        checkOutput("flush_dropped", {63'd0, bus.out_valid}, 64'd0);

        // Unsupported funct still travels down with the illegal flag.
        setInstr(2'b10, 6'b000000, 1, 2, 4, 32'h10, 32'h20);
        applyStimulus();
        checkOutput("illegal_flag",   {63'd0, bus.out_illegal}, 64'd1);
        checkOutput("illegal_signal", {62'd0, bus.out_signal}, 64'd2);
        checkOutput("illegal_valid",  {63'd0, bus.out_valid}, 64'd1);

        // Back-to-back stream of four.
        for (int k = 0; k < 4; k++) begin
            setInstr(2'b00, 0, 1, 2, 5'(10 + k), 32'(k), 32'(k + 100));
            applyStimulus();
            checkOutput("stream_valid", {63'd0, bus.out_valid}, 64'd1);
            checkOutput("stream_rd",    {59'd0, bus.out_rd_addr}, 64'(10 + k));
        end
        bus.in_valid = 0;
        applyStimulus();
        checkOutput("stream_end", {63'd0, bus.out_valid}, 64'd0);

        // Random traffic; small register range makes forwarding hits common.
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 49) == 0);
            bus.flush = ($urandom_range(0, 19) == 0);
            bus.out_ready = ($urandom_range(0, 9) < 6);
            setInstr(2'($urandom_range(0, 3)), functs[$urandom_range(0, 5)],
                     5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                     5'($urandom), $urandom, $urandom);
            bus.in_valid = ($urandom_range(0, 9) < 7);
            bus.fwd_exmem_we = $urandom_range(0, 1) == 1;
            bus.fwd_exmem_addr = 5'($urandom_range(0, 3));
            bus.fwd_exmem_data = $urandom;
            bus.fwd_memwb_we = $urandom_range(0, 1) == 1;
            bus.fwd_memwb_addr = 5'($urandom_range(0, 3));
            bus.fwd_memwb_data = $urandom;
            applyStimulus();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
